// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit types and lock FSM state for the input buffer bank
package noc_pkg;

    localparam int DATA_W = 8;

    typedef struct packed {
        logic              tail;
        logic [DATA_W-1:0] data;
    } flit_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/flit_fifo.sv
// rtl/flit_fifo.sv - single-lane synchronous flit FIFO
//  clk, reset        clock, synchronous active-low reset
//  push, wdata       write request and word; ignored while full
//  pop               read request; ignored while empty
//  full, empty       occupancy flags
//  head              oldest stored word (undefined while empty)
module flit_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Full is judged on registered occupancy, so a pop never frees a slot
    // for a push in the same cycle.
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/input_buffer_bank.sv
// rtl/input_buffer_bank.sv - N-lane input flit buffer with wormhole lock feeding a grant arbiter
//  clk, reset              clock, synchronous active-low reset
//  in_valid/in_ready       per-lane flit handshake; in_data lane i at [i*DATA_W +: DATA_W]
//  in_tail                 per-lane last-flit marker
//  req/gnt                 arbiter request out, one-hot-or-zero grant in
//  arb_en                  arbiter enable (follows out_ready)
//  arb_update_en           arbiter priority rotate, pulses on tail dequeue
//  out_valid/out_ready     forwarded flit handshake
//  out_data/out_tail       forwarded flit, zero when out_valid is low
module input_buffer_bank
    import noc_pkg::*;
#(
    parameter int N      = 4,
    parameter int DEPTH  = 4,
    parameter int DATA_W = noc_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        in_valid,
    output logic [N-1:0]        in_ready,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic [N-1:0]        in_tail,
    output logic [N-1:0]        req,
    input  logic [N-1:0]        gnt,
    output logic                arb_en,
    output logic                arb_update_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_tail
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]      full;
    logic [N-1:0]      empty;
    logic [N-1:0]      deq;
    logic [N-1:0]      hit;
    logic [DATA_W:0]   head [N];
    logic [LW-1:0]     sel;
    logic              fire;
    lock_state_t       lock_state;
    logic [LW-1:0]     lock_idx;

    for (genvar g = 0; g < N; g++) begin : g_lane
        flit_fifo #(
            .DEPTH (DEPTH),
            .W     (DATA_W + 1)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (in_valid[g]),
            .pop   (deq[g]),
            .wdata ({in_tail[g], in_data[g*DATA_W +: DATA_W]}),
            .full  (full[g]),
            .empty (empty[g]),
            .head  (head[g])
        );
    end

    assign in_ready = ~full;
    assign arb_en   = out_ready;

    // While a packet is in flight only the locked lane may compete.
    always_comb begin
        req = '0;
        for (int i = 0; i < N; i++) begin
            req[i] = ~empty[i] & ((lock_state == UNLOCKED) | (lock_idx == LW'(i)));
        end
    end

    // A multi-hot grant is resolved to its lowest set index.
    always_comb begin
        hit = gnt & req;
        sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel = LW'(i);
            end
        end
    end

    assign out_valid     = |hit;
    assign out_data      = out_valid ? head[sel][DATA_W-1:0] : '0;
    assign out_tail      = out_valid ? head[sel][DATA_W] : 1'b0;
    assign fire          = out_valid & out_ready;
    assign deq           = fire ? (N'(1) << sel) : '0;
    assign arb_update_en = fire & out_tail;

    always_ff @(posedge clk) begin
        if (!reset) begin
            lock_state <= UNLOCKED;
            lock_idx   <= '0;
        end else if (fire) begin
            case (lock_state)
                UNLOCKED: begin
                    // A head=tail flit completes its packet at once and never locks.
                    if (!out_tail) begin
                        lock_state <= LOCKED;
                        lock_idx   <= sel;
                    end
                end
                LOCKED: begin
                    if (out_tail && sel == lock_idx) begin
                        lock_state <= UNLOCKED;
                    end
                end
                default: lock_state <= UNLOCKED;
            endcase
        end
    end

    gnt_onehot_a: assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt));

endmodule

// File: tb/tb_input_buffer_bank.sv
// tb/tb_input_buffer_bank.sv - self-checking bench for input_buffer_bank with a round-robin arbiter
module tb_input_buffer_bank;
    import noc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_tail;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        arb_en;
    logic        arb_update_en;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_tail;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int    lane;
        flit_t f;
    } log_t;

    flit_t mq [4][$];
    log_t  outlog [$];
    bit    mlock;
    int    midx;

    always #5 clk = ~clk;

    input_buffer_bank #(.N(4), .DEPTH(4), .DATA_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_tail       (in_tail),
        .req           (req),
        .gnt           (gnt),
        .arb_en        (arb_en),
        .arb_update_en (arb_update_en),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_tail      (out_tail)
    );

    // Round-robin arbiter: search starts at ptr, rotates past the winner on update.
    logic [1:0] ptr;
    logic [1:0] gsel;
    always_comb begin
        logic [1:0] j;
        gnt  = '0;
        gsel = '0;
        for (int k = 0; k < 4; k++) begin
            j = ptr + 2'(k);
            if (gnt == 4'b0 && req[j] === 1'b1) begin
                gnt[j] = 1'b1;
                gsel   = j;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) ptr <= '0;
        else if (arb_en && arb_update_en && gnt != 4'b0) ptr <= gsel + 2'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < 4; i++) if (mq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: compare outputs against the model at negedge, then advance the model at posedge.
    task automatic cycle();
        logic [3:0] er, eir, hit, push;
        int    g;
        logic  ev;
        flit_t ef;
        @(negedge clk);
        er  = '0;
        eir = '0;
        for (int i = 0; i < 4; i++) begin
            eir[i] = (mq[i].size() < 4);
            er[i]  = (mq[i].size() != 0) && (!mlock || midx == i);
        end
        hit = gnt & er;
        ev  = |hit;
        g   = 0;
        for (int i = 3; i >= 0; i--) if (hit[i]) g = i;
        ef = '0;
        if (ev) ef = mq[g][0];
        if (reset) begin
            chk("req", 32'(req), 32'(er));
            chk("in_ready", 32'(in_ready), 32'(eir));
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("out_data", 32'(out_data), 32'(ef.data));
            chk("out_tail", 32'(out_tail), 32'(ef.tail));
            chk("arb_update_en", 32'(arb_update_en), 32'(ev & out_ready & ef.tail));
            chk("arb_en", 32'(arb_en), 32'(out_ready));
            if (out_valid === 1'b1 && out_ready)
                outlog.push_back('{int'(gsel), flit_t'{out_tail, out_data}});
        end
        push = in_valid & eir;
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            mlock = 1'b0;
            midx  = 0;
        end else begin
            if (ev && out_ready) begin
                void'(mq[g].pop_front());
                if (!mlock && !ef.tail) begin
                    mlock = 1'b1;
                    midx  = g;
                end else if (mlock && ef.tail && g == midx) begin
                    mlock = 1'b0;
                end
            end
            for (int i = 0; i < 4; i++)
                if (push[i]) mq[i].push_back(flit_t'{in_tail[i], in_data[i*8 +: 8]});
        end
        #1;
    endtask

    task automatic drain(input int budget, input bit toggle);
        int n = 0;
        while (any_pending() && n < budget) begin
            if (toggle) out_ready = ~out_ready;
            cycle();
            n++;
        end
        chk("drain_bound", 32'(n < budget), 32'd1);
    endtask

    initial begin
        int b;
        int c;
        mlock     = 1'b0;
        midx      = 0;
        reset     = 1'b0;
        in_valid  = 4'hF;
        in_data   = '0;
        in_tail   = '0;
        out_ready = 1'b0;

        // 1: reset with all lanes offering
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'hF);
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_tail", 32'(out_tail), 32'h0);
        chk("rst_update", 32'(arb_update_en), 32'h0);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 4'h0;

        // 2: fill lane 2 while stalled, overflow attempt, then drain in order
        for (int k = 0; k < 5; k++) begin
            in_valid       = 4'b0100;
            in_tail        = 4'b0100;
            in_data[16+:8] = 8'h10 + 8'(k);
            cycle();
            if (k == 3) begin
                chk("full_in_ready2", 32'(in_ready[2]), 32'h0);
                chk("full_req", 32'(req), 32'h4);
            end
        end
        in_valid  = 4'h0;
        out_ready = 1'b1;
        b = outlog.size();
        drain(10, 1'b0);
        chk("fill_count", 32'(outlog.size() - b), 32'd4);
        for (int k = 0; k < 4 && b + k < outlog.size(); k++)
            chk("fill_order", 32'(outlog[b+k].f.data), 32'h10 + 32'(k));

        // 3: wormhole lock, lane 0 three-flit packet vs lane 1 single flit
        b = outlog.size();
        in_valid = 4'b0011; in_tail = 4'b0010;
        in_data[0+:8] = 8'hA0; in_data[8+:8] = 8'hB0;
        cycle();
        in_valid = 4'b0001; in_tail = 4'b0000; in_data[0+:8] = 8'hA1;
        cycle();
        in_valid = 4'b0001; in_tail = 4'b0001; in_data[0+:8] = 8'hA2;
        cycle();
        in_valid = 4'h0; in_tail = 4'h0;
        drain(10, 1'b0);
        chk("lock_count", 32'(outlog.size() - b), 32'd4);
        if (outlog.size() - b == 4) begin
            chk("lock_seq0", 32'(outlog[b].f), 32'h0A0);
            chk("lock_seq1", 32'(outlog[b+1].f), 32'h0A1);
            chk("lock_seq2", 32'(outlog[b+2].f), 32'h1A2);
            chk("lock_seq3", 32'(outlog[b+3].f), 32'h1B0);
        end

        // 4: single-flit packets on every lane, round-robin service
        b = outlog.size();
        in_tail = 4'hF;
        for (c = 0; c < 12; c++) begin
            in_valid = 4'hF;
            for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = {4'(i), 4'(c)};
            cycle();
        end
        in_valid = 4'h0;
        drain(60, 1'b0);
        chk("rr_enough", 32'(outlog.size() - b >= 12), 32'd1);
        for (int j = 1; j < 12 && b + j < outlog.size(); j++)
            chk("rr_rotate", 32'(outlog[b+j].f.data[7:4]),
                32'((outlog[b+j-1].f.data[7:4] + 4'd1) & 4'h3));

        // 5: out_ready toggled during a four-flit packet on lane 3
        b = outlog.size();
        for (int k = 0; k < 4; k++) begin
            out_ready = k[0];
            in_valid  = (k == 0) ? 4'b1001 : 4'b1000;
            in_tail   = (k == 3) ? 4'b1001 : 4'b0001;
            in_data[24+:8] = 8'hC0 + 8'(k);
            in_data[0+:8]  = 8'hD0;
            cycle();
        end
        in_valid = 4'h0; in_tail = 4'h0;
        drain(30, 1'b1);
        chk("stall_count", 32'(outlog.size() - b), 32'd5);
        c = 0;
        for (int j = b; j < outlog.size(); j++) begin
            if (outlog[j].f.data[7:4] == 4'hC) begin
                chk("stall_order", 32'(outlog[j].f.data), 32'hC0 + 32'(c));
                c++;
            end
        end
        chk("stall_lane3_count", 32'(c), 32'd4);

        // 6: reset while lane 3 holds the lock
        out_ready = 1'b1;
        in_valid = 4'b1000; in_tail = 4'b0000; in_data[24+:8] = 8'hE0;
        cycle();
        in_valid = 4'b1010; in_tail = 4'b0010;
        in_data[24+:8] = 8'hE1; in_data[8+:8] = 8'hF0;
        cycle();
        chk("locked_req", 32'(req), 32'h8);
        in_valid = 4'h0; in_tail = 4'h0;
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        chk("rst2_req", 32'(req), 32'h0);
        chk("rst2_in_ready", 32'(in_ready), 32'hF);
        chk("rst2_out_valid", 32'(out_valid), 32'h0);
        in_valid = 4'b0010; in_tail = 4'b0010; in_data[8+:8] = 8'h51;
        cycle();
        in_valid = 4'h0; in_tail = 4'h0;
        chk("post_rst_req", 32'(req), 32'h2);
        drain(10, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
